pkt_patt_match: RTL and testbench

Parametrised, pipelined multi-context pattern matcher for the network accelerator. It scans the 64-bit packet words issued by each hardware thread for a programmable byte pattern, including matches that straddle two words. Patterns are register-loaded per (core, thread) context instead of hard-coded. History is kept per context, so words from different threads may interleave freely. It reports one result per packet: match flag, match count and byte offset of the first match.

---
 rtl/pkt_patt_match.sv | 184 ++++++++++++++++++
 tb/tb_pkt_patt_match.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_patt_match.sv
// rtl/pkt_patt_match.sv - multi-context byte-pattern matcher over a packet word stream
module pkt_patt_match #(
    parameter int DATA_W      = 64,
    parameter int PATT_BYTES  = 7,
    parameter int NUM_CORES   = 2,
    parameter int NUM_THREADS = 4,
    parameter int OFFS_W      = 16,
    parameter int CNT_W       = 8,
    localparam int L      = DATA_W / 8,
    localparam int P      = PATT_BYTES,
    localparam int H      = P - 1,
    localparam int C      = NUM_CORES * NUM_THREADS,
    localparam int CTX_W  = (C > 1) ? $clog2(C) : 1,
    localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int THR_W  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CTX_W-1:0]    cfg_ctx,
    input  logic [8*P-1:0]      cfg_patt,
    input  logic                cfg_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    input  logic [CORE_W-1:0]   in_core,
    input  logic [THR_W-1:0]    in_thread,
    input  logic                match_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTX_W-1:0]    out_ctx,
    output logic                out_match,
    output logic [CNT_W-1:0]    out_count,
    output logic [OFFS_W-1:0]   out_offset
);

    localparam int LANE_W = $clog2(L + 1);
    localparam int SW     = OFFS_W + LANE_W + 4;
    localparam int CS_W   = CNT_W + LANE_W;

    // Per-context configuration, history and packet accumulators
    logic [8*P-1:0]    patt     [C];
    logic [C-1:0]      en;
    logic [8*H-1:0]    hist     [C];
    logic [C-1:0]      hist_valid;
    logic [OFFS_W-1:0] word_idx [C];
    logic [C-1:0]      acc_seen;
    logic [CNT_W-1:0]  acc_cnt  [C];
    logic [OFFS_W-1:0] acc_off  [C];

    logic              advance;
    logic              accept;
    logic [CTX_W-1:0]  in_ctx;
    logic [8*(H+L)-1:0] window;
    logic [L-1:0]      hits;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;
    assign accept   = in_valid && advance;
    assign in_ctx   = CTX_W'(in_core) * CTX_W'(NUM_THREADS) + CTX_W'(in_thread);
    assign window   = {in_data, hist[in_ctx]};

    // Lanes whose window reaches into a missing previous word are masked
    always_comb begin
        hits = '0;
        for (int k = 0; k < L; k++) begin
            if ((hist_valid[in_ctx] || k >= H) && window[8*k +: 8*P] == patt[in_ctx])
                hits[k] = en[in_ctx] & match_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C; i++) begin
                patt[i]     <= '0;
                hist[i]     <= '0;
                word_idx[i] <= '0;
            end
            en         <= '0;
            hist_valid <= '0;
        end else begin
            if (cfg_we) begin
                patt[cfg_ctx] <= cfg_patt;
                en[cfg_ctx]   <= cfg_en;
            end
            if (accept) begin
                hist[in_ctx]       <= in_data[DATA_W-1 -: 8*H];
                hist_valid[in_ctx] <= !in_last;
                if (in_last)
                    word_idx[in_ctx] <= '0;
                else if (word_idx[in_ctx] != {OFFS_W{1'b1}})
                    word_idx[in_ctx] <= word_idx[in_ctx] + OFFS_W'(1);
            end
        end
    end

    logic              s1_valid;
    logic              s1_last;
    logic [L-1:0]      s1_hits;
    logic [CTX_W-1:0]  s1_ctx;
    logic [OFFS_W-1:0] s1_widx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_hits  <= '0;
            s1_ctx   <= '0;
            s1_widx  <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            s1_last  <= in_last;
            s1_hits  <= hits;
            s1_ctx   <= in_ctx;
            s1_widx  <= word_idx[in_ctx];
        end
    end

    logic [LANE_W-1:0] pop;
    logic [LANE_W-1:0] first_lane;
    logic [CS_W-1:0]   cnt_sum;
    logic [SW-1:0]     start_full;
    logic [OFFS_W-1:0] start_sat;
    logic              nxt_seen;
    logic [CNT_W-1:0]  nxt_cnt;
    logic [OFFS_W-1:0] nxt_off;

    always_comb begin
        pop        = '0;
        first_lane = '0;
        for (int k = L - 1; k >= 0; k--) begin
            if (s1_hits[k])
                first_lane = LANE_W'(k);
        end
        for (int k = 0; k < L; k++)
            pop = pop + LANE_W'(s1_hits[k]);
        cnt_sum    = CS_W'(acc_cnt[s1_ctx]) + CS_W'(pop);
        nxt_cnt    = (|cnt_sum[CS_W-1:CNT_W]) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        // Only valid lanes can hit, so the start never goes below zero
        start_full = SW'(s1_widx) * SW'(L) + SW'(first_lane) - SW'(H);
        start_sat  = (|start_full[SW-1:OFFS_W]) ? {OFFS_W{1'b1}} : start_full[OFFS_W-1:0];
        nxt_seen   = acc_seen[s1_ctx] | (|s1_hits);
        if (acc_seen[s1_ctx])
            nxt_off = acc_off[s1_ctx];
        else if (|s1_hits)
            nxt_off = start_sat;
        else
            nxt_off = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < C; i++) begin
                acc_cnt[i] <= '0;
                acc_off[i] <= '0;
            end
            acc_seen   <= '0;
            out_valid  <= 1'b0;
            out_ctx    <= '0;
            out_match  <= 1'b0;
            out_count  <= '0;
            out_offset <= '0;
        end else if (advance) begin
            out_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    out_ctx            <= s1_ctx;
                    out_match          <= nxt_seen;
                    out_count          <= nxt_cnt;
                    out_offset         <= nxt_off;
                    acc_seen[s1_ctx]   <= 1'b0;
                    acc_cnt[s1_ctx]    <= '0;
                    acc_off[s1_ctx]    <= '0;
                end else begin
                    acc_seen[s1_ctx]   <= nxt_seen;
                    acc_cnt[s1_ctx]    <= nxt_cnt;
                    acc_off[s1_ctx]    <= nxt_off;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_patt_match.sv
// tb/tb_pkt_patt_match.sv - randomized scoreboard bench for pkt_patt_match
module tb_pkt_patt_match;

    localparam int P = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_ctx = '0;
    logic [55:0] cfg_patt = '0;
    logic        cfg_en = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [0:0]  in_core = '0;
    logic [1:0]  in_thread = '0;
    logic        match_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_ctx;
    logic        out_match;
    logic [7:0]  out_count;
    logic [15:0] out_offset;

    always #5 clk = ~clk;

    pkt_patt_match dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_ctx(cfg_ctx), .cfg_patt(cfg_patt), .cfg_en(cfg_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .in_core(in_core), .in_thread(in_thread), .match_en(match_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctx(out_ctx),
        .out_match(out_match), .out_count(out_count), .out_offset(out_offset)
    );

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 0;

    // Reference: each context keeps the raw bytes of its current packet
    logic [55:0] m_patt [8];
    bit          m_en   [8];
    logic [7:0]  m_pk   [8][64];
    int          m_len  [8];
    int          m_cnt  [8];
    int          m_first[8];
    logic [27:0] exp_q  [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 8; c++) begin
            m_patt[c] = '0; m_en[c] = 0; m_len[c] = 0; m_cnt[c] = 0; m_first[c] = -1;
        end
    endtask

    task automatic model_accept(int c, logic [63:0] d, bit last, bit men);
        int base = m_len[c];
        for (int j = 0; j < 8; j++)
            if (base + j < 64) m_pk[c][base + j] = d[8*j +: 8];
        m_len[c] = base + 8;
        for (int j = 0; j < 8; j++) begin
            int s = base + j - (P - 1);
            if (s >= 0 && m_en[c] && men) begin
                bit eq = 1;
                for (int i = 0; i < P; i++)
                    if (m_pk[c][s + i] != m_patt[c][8*i +: 8]) eq = 0;
                if (eq) begin
                    if (m_cnt[c] < 255) m_cnt[c]++;
                    if (m_first[c] < 0) m_first[c] = s;
                end
            end
        end
        if (last) begin
            exp_q.push_back({3'(c), m_first[c] >= 0, 8'(m_cnt[c]),
                             16'((m_first[c] < 0) ? 0 : m_first[c])});
            m_len[c] = 0; m_cnt[c] = 0; m_first[c] = -1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: any presented result must equal the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_result: got ctx %0d count %0d, expected no result", out_ctx, out_count);
            end else begin
                check("result", {out_ctx, out_match, out_count, out_offset}, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cfg(int c, logic [55:0] p, bit e);
        cfg_we = 1'b1; cfg_ctx = 3'(c); cfg_patt = p; cfg_en = e;
        @(negedge clk);
        m_patt[c] = p; m_en[c] = e;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(int c, logic [63:0] d, bit last, bit men);
        bit done = 0;
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = last; match_en = men;
        in_core = 1'(c / 4); in_thread = 2'(c % 4);
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(c, d, last, men);
                done = 1;
            end
            if (cfg_we) begin
                m_patt[cfg_ctx] = cfg_patt; m_en[cfg_ctx] = cfg_en;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            n++;
            if (!done && n >= 50) begin
                vectors++; miscompares++;
                $display("FAIL in_ready_timeout: in_ready 0 for %0d cycles, expected 1", n);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(string name, logic [27:0] exp);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, {out_valid, out_ctx, out_match, out_count, out_offset}, {1'b1, exp});
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_pending", exp_q.size(), 0);
    endtask

    function automatic logic [63:0] rnd_word();
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = ($urandom_range(0, 3) == 0) ? 8'hB5 : 8'h5A;
        return w;
    endfunction

    function automatic logic [55:0] rnd_patt();
        logic [55:0] p;
        for (int j = 0; j < P; j++) p[8*j +: 8] = ($urandom_range(0, 5) == 0) ? 8'hB5 : 8'h5A;
        return p;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int left [8];
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {out_valid, out_ctx, out_match, out_count, out_offset}, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        cfg(2, {7{8'h77}}, 1);
        cfg(5, {7{8'h78}}, 1);

        // Single-word match with latency check
        send(2, 64'h7777777777777700, 1, 1);
        @(negedge clk);
        check("latency_t1_valid", out_valid, 0);
        @(negedge clk);
        check("latency_t2", {out_valid, out_ctx, out_match, out_count, out_offset},
              {1'b1, 3'd2, 1'b1, 8'd1, 16'd1});
        @(posedge clk); #1;

        // Cross-word match
        send(2, 64'h7777770000000000, 0, 1);
        send(2, 64'h0000000077777777, 1, 1);
        wait_result("cross_word", {3'd2, 1'b1, 8'd1, 16'd5});

        // Interleaved contexts
        send(2, 64'h7777770000000000, 0, 1);
        send(5, 64'h7878780000000000, 0, 1);
        send(2, 64'h0000000078787878, 0, 1);
        send(5, 64'h0000000077777777, 0, 1);
        send(2, 64'h0000000077777777, 1, 1);
        send(5, 64'h0000000078787878, 1, 1);
        wait_drain();

        // Suppression, history through a suppressed word, disabled context
        cfg(3, {7{8'h77}}, 0);
        send(2, 64'h7777777777777700, 1, 0);
        wait_result("suppressed", {3'd2, 1'b0, 8'd0, 16'd0});
        send(2, 64'h7777777777777777, 0, 0);
        send(2, 64'h7777777777777777, 1, 1);
        wait_result("hist_after_suppress", {3'd2, 1'b1, 8'd8, 16'd2});
        send(3, 64'h7777777777777777, 1, 1);
        wait_result("disabled_ctx", {3'd3, 1'b0, 8'd0, 16'd0});

        // Backpressure: results stall behind out_ready=0
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send(2, 64'h7777777777777777, 1, 1);
        fork
            begin
                send(5, 64'h7878787878787878, 1, 1);
                send(2, 64'h0077777777777777, 1, 1);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                repeat (4) @(posedge clk);
                #1;
                rdy_mode = 0;
            end
        join
        wait_drain();

        // Reset mid-packet
        send(2, 64'h7777777777777777, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("midrst_outputs", {out_valid, out_count, out_offset}, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cfg(2, {7{8'h77}}, 1);
        send(2, 64'h7777777777777777, 1, 1);
        wait_result("after_reset", {3'd2, 1'b1, 8'd2, 16'd0});

        // Randomized interleaved traffic with random backpressure and reconfiguration
        for (int c = 0; c < 8; c++) begin
            cfg(c, rnd_patt(), $urandom_range(0, 5) != 0);
            left[c] = 0;
        end
        rdy_mode = 1;
        for (int it = 0; it < 500; it++) begin
            int c = $urandom_range(0, 7);
            if (left[c] == 0) left[c] = $urandom_range(1, 4);
            if ($urandom_range(0, 15) == 0) begin
                cfg_we = 1'b1;
                cfg_ctx = 3'($urandom_range(0, 7));
                cfg_patt = rnd_patt();
                cfg_en = ($urandom_range(0, 5) != 0);
            end
            send(c, rnd_word(), left[c] == 1, $urandom_range(0, 7) != 0);
            left[c]--;
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        for (int c = 0; c < 8; c++)
            if (left[c] > 0) send(c, rnd_word(), 1, 1);
        rdy_mode = 0;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
